// File: rtl/mul_tile_seq_pkg.sv
// Shared types and constants for the tiled sequential multiplier.
// Holds the FSM encoding, tile width and step-count helper.
package mul_tile_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int TILE_W = 4;

    function automatic int step_count(input int nib);
        return nib * nib;
    endfunction

endpackage

// File: rtl/mul4x4_wt.sv
// 4x4 unsigned multiplier tile reduced to two carry-save rows.
// The caller resolves sum0_o + sum1_o (mod 256) into the product.
module mul4x4_wt
    import mul_tile_seq_pkg::*;
(
    input  logic [TILE_W-1:0]   x_i,
    input  logic [TILE_W-1:0]   y_i,
    output logic [2*TILE_W-1:0] sum0_o,
    output logic [2*TILE_W-1:0] sum1_o
);

    logic [2*TILE_W-1:0] r0, r1, r2, r3;
    logic [2*TILE_W-1:0] s, c;

    always_comb begin
        r0 = {4'b0, x_i & {4{y_i[0]}}};
        r1 = {3'b0, x_i & {4{y_i[1]}}, 1'b0};
        r2 = {2'b0, x_i & {4{y_i[2]}}, 2'b0};
        r3 = {1'b0, x_i & {4{y_i[3]}}, 3'b0};
        // Two 3:2 compressor levels: four rows down to two.
        s      = r0 ^ r1 ^ r2;
        c      = ((r0 & r1) | (r0 & r2) | (r1 & r2)) << 1;
        sum0_o = s ^ c ^ r3;
        sum1_o = ((s & c) | (s & r3) | (c & r3)) << 1;
    end

endmodule

// File: rtl/mul_tile_seq.sv
// Iterative WIDTH x WIDTH unsigned multiplier sharing one 4x4 tile.
// One nibble pair per cycle; partial products shift-accumulated.
module mul_tile_seq
    import mul_tile_seq_pkg::*;
#(
    parameter int WIDTH = 8
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
);

    localparam int NIB   = WIDTH / TILE_W;
    localparam int STEPS = step_count(NIB);
    localparam int IW    = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int PW    = 2 * WIDTH;
    localparam int SHW   = 5;
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    if ((WIDTH % TILE_W) != 0 || STEPS < 1 || STEPS > 16) begin : g_bad_width
        $error("mul_tile_seq: WIDTH must be 4, 8, 12 or 16");
    end

    state_e          state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [PW-1:0]   acc_q, acc_d, p_q, p_d;
    logic [IW-1:0]   i_q, i_d, j_q, j_d;

    logic [TILE_W-1:0]   a_nib, b_nib;
    logic [2*TILE_W-1:0] sum0, sum1, pp;
    logic [PW-1:0]       pp_ext;
    logic [SHW-1:0]      sh;

    assign a_nib = a_q[TILE_W*int'(i_q) +: TILE_W];
    assign b_nib = b_q[TILE_W*int'(j_q) +: TILE_W];

    mul4x4_wt u_tile (
        .x_i    (a_nib),
        .y_i    (b_nib),
        .sum0_o (sum0),
        .sum1_o (sum1)
    );

    // Exact in 8 bits: a 4x4 product never exceeds 225.
    assign pp     = sum0 + sum1;
    assign pp_ext = PW'(pp);
    assign sh     = SHW'(TILE_W) * (SHW'(i_q) + SHW'(j_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        p_d     = p_q;
        i_d     = i_q;
        j_d     = j_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                acc_d = acc_q + (pp_ext << sh);
                if (j_q == LAST) begin
                    j_d = '0;
                    i_d = i_q + 1'b1;
                end else begin
                    j_d = j_q + 1'b1;
                end
                if (i_q == LAST && j_q == LAST) begin
                    i_d     = '0;
                    p_d     = acc_d;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == MUL) || (state_q == DONE);
    assign p         = p_q;

endmodule

// File: doc/mul_tile_seq.md
Name: mul_tile_seq

Overview:
- Iterative unsigned WIDTH x WIDTH multiplier controller.
- Time-shares a single 4x4 carry-save multiplier tile across all nibble pairs of the operands.
- Resolves each tile's two carry-save rows, shifts the partial product, and accumulates it into a 2*WIDTH result.
- Sits between an upstream valid/ready producer and a downstream valid/ready consumer; trades latency for area against a full-width array.

Parameters:
- WIDTH, 8, operand width in bits; legal values 4, 8, 12, 16 (multiple of 4). Elaboration error otherwise.
- NIB (derived), WIDTH/4, nibbles per operand; the step count is NIB*NIB.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands a/b valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  multiplicand, unsigned.
- b  input  WIDTH  multiplier, unsigned.
- out_valid  output  1  product p valid.
- out_ready  input  1  consumer accepts p.
- p  output  2*WIDTH  product a*b.
- busy  output  1  high in MUL or DONE.

Behaviour:
- Reset is asynchronous and active-high on rst. Reset values:
  - state=IDLE
  - in_ready=1, out_valid=0, busy=0
  - p=0, accumulator=0, step counters i=j=0
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready:
    - latch a, b into operand registers
    - clear acc
    - set i=j=0
    - go to MUL
  - MUL: in_ready=0, busy=1. Each cycle:
    - tile inputs = a_reg nibble i, b_reg nibble j
    - pp = (sum0 + sum1) mod 256, which is exact because 15*15=225
    - acc += zero-extend(pp) << 4*(i+j)
    - advance j; when j wraps from NIB-1, advance i
    - after the step with i=j=NIB-1, go to DONE with p = final acc
  - DONE: out_valid=1, p held stable. On out_ready go to IDLE and drop out_valid; the next operands are accepted no earlier than the following cycle.
- Latency:
  - Accept edge to out_valid rising = NIB*NIB cycles (4 for WIDTH=8).
  - Throughput: one product per NIB*NIB+2 cycles minimum.
- Width rules:
  - acc is 2*WIDTH bits and never overflows.
  - Every partial-product add is unsigned modulo 2^(2*WIDTH).
- Boundary conditions:
  - in_valid outside IDLE: ignored. Operands are not re-sampled; a/b may change freely after acceptance.
  - out_ready while not DONE: ignored.
  - out_ready held low: stay in DONE indefinitely; p and out_valid stable.
  - WIDTH=4: exactly one MUL cycle.
  - Zero operands: still run all steps; no early exit.
  - rst asserted mid-MUL or in DONE: immediate return to reset values. The in-flight product is discarded and no out_valid pulse follows.

Decomposition:
- Shared package:
  - state encoding IDLE/MUL/DONE (2-bit)
  - tile width constant TILE_W=4
  - step-count function NIB*NIB
- One sub-module, the existing 4x4 carry-save tile mul4x4_wt, instantiated once, combinationally between the operand nibble muxes and the adder.
- Everything else (nibble muxes, 8-bit row resolve, shift-add, FSM) lives in mul_tile_seq.

Test Plan:
1. WIDTH=8, a=0x12, b=0x34, out_ready=1 -> out_valid exactly 4 cycles after accept, p=0x03A8, in_ready back to 1 the cycle after the handshake.
2. a=0xFF, b=0xFF -> p=0xFE01. Then a=0x00, b=0xA7 -> p=0x0000 with full 4-cycle latency.
3. a=0xA5, b=0x5A with out_ready low for 3 cycles after out_valid -> p=0x3A02 held stable and out_valid held high. An in_valid pulse with a=0x01, b=0x01 during that window is ignored. Completes on out_ready.
4. Change a/b every cycle during MUL after accepting a=0x0F, b=0xF0 -> p=0x0E10.
5. Assert rst asynchronously on the 3rd MUL cycle -> outputs at reset values immediately, no out_valid. The next transaction a=0x03, b=0x05 yields p=0x000F.
6. WIDTH=4, a=0xF, b=0xD -> out_valid 1 cycle after accept, p=0xC3. WIDTH=16, a=0xFFFF, b=0xFFFF -> 16-cycle latency, p=0xFFFE0001.
